// File: rtl/div_repsub.sv
// Sequential unsigned 16-bit divider by repeated subtraction with a start/done handshake.
// Optional macro DIV_DZ_CHECK_EN: divide-by-zero detection in CHK, reported on err.
`timescale 1ns/1ps

module div_repsub (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] data_in,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDA  = 3'd1,
        S_LDB  = 3'd2,
        S_CHK  = 3'd3,
        S_CALC = 3'd4,
        S_DONE = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] quot_q, quot_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] dvsr_q, dvsr_d;
`ifdef DIV_DZ_CHECK_EN
    logic        err_q, err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            quot_q  <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
`ifdef DIV_DZ_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
`ifdef DIV_DZ_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
`ifdef DIV_DZ_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: if (start) state_d = S_LDA;
            S_LDA: begin
                rem_d   = data_in;
                state_d = S_LDB;
            end
            S_LDB: begin
                dvsr_d  = data_in;
                quot_d  = '0;
`ifdef DIV_DZ_CHECK_EN
                err_d   = 1'b0;
`endif
                state_d = S_CHK;
            end
            S_CHK: begin
`ifdef DIV_DZ_CHECK_EN
                if (dvsr_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
`else
                state_d = S_CALC;
`endif
            end
            S_CALC: begin
                // Saturation guard bounds a zero-divisor run at 16'hFFFF iterations.
                if ((rem_q >= dvsr_q) && (quot_q != 16'hFFFF)) begin
                    rem_d  = rem_q - dvsr_q;
                    quot_d = quot_q + 16'd1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: if (!start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign busy      = (state_q == S_LDA) || (state_q == S_LDB) ||
                       (state_q == S_CHK) || (state_q == S_CALC);
    assign done      = (state_q == S_DONE);
`ifdef DIV_DZ_CHECK_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_div_repsub.sv
// Self-checking bench for div_repsub: directed boundary cases, randomized operands, handshake and reset.
`timescale 1ns/1ps

module tb_div_repsub;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] data_in;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    div_repsub dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data_in  (data_in),
        .quotient (quotient),
        .remainder(remainder),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DIV_DZ_CHECK_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    // Reference: plain integer division plus the documented zero-divisor behaviour.
    task automatic ref_div(input int unsigned a, input int unsigned b,
                           output int unsigned q, output int unsigned r,
                           output bit e, output int unsigned lat);
        if (b == 0) begin
            r = a;
            if (DZ_EN) begin q = 0; e = 1'b1; lat = 4; end
            else begin q = 65535; e = 1'b0; lat = 65540; end
        end else begin
            q = a / b; r = a % b; e = 1'b0; lat = q + 5;
        end
    endtask

    // Starts at #1 after an edge with the DUT in IDLE; returns edges until done seen.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input bit chk_busy, output int unsigned edges);
        start = 1'b1; data_in = a; edges = 0;
        @(posedge clk); #1; edges = 1; start = 1'b0;
        @(posedge clk); #1; edges = 2; data_in = b;
        while (!done && edges < 70000) begin
            if (chk_busy) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_during_op edge=%0d busy=%b expected 1", edges, busy);
                end
            end
            @(posedge clk); #1; edges++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL op_timeout a=%0d b=%0d done=%b expected 1", a, b, done);
        end
    endtask

    task automatic check_op(input string name, input logic [15:0] a, input logic [15:0] b,
                            input bit chk_busy);
        int unsigned eq, er, elat, edges;
        bit ee;
        ref_div(a, b, eq, er, ee, elat);
        do_op(a, b, chk_busy, edges);
        checks++;
        if (quotient !== eq[15:0]) begin
            errors++;
            $display("FAIL %s_quotient a=%0d b=%0d got %0d expected %0d", name, a, b, quotient, eq);
        end
        checks++;
        if (remainder !== er[15:0]) begin
            errors++;
            $display("FAIL %s_remainder a=%0d b=%0d got %0d expected %0d", name, a, b, remainder, er);
        end
        checks++;
        if (err !== ee) begin
            errors++;
            $display("FAIL %s_err a=%0d b=%0d got %b expected %b", name, a, b, err, ee);
        end
        checks++;
        if (edges != elat) begin
            errors++;
            $display("FAIL %s_latency a=%0d b=%0d got %0d expected %0d", name, a, b, edges, elat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_in_done got %b expected 0", name, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || quotient !== eq[15:0] || remainder !== er[15:0]) begin
            errors++;
            $display("FAIL %s_idle_hold done=%b q=%0d r=%0d expected done=0 q=%0d r=%0d",
                     name, done, quotient, remainder, eq, er);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({quotient, remainder, busy, done, err} !== 35'd0) begin
            errors++;
            $display("FAIL reset_hold q=%0d r=%0d busy=%b done=%b err=%b expected all 0",
                     quotient, remainder, busy, done, err);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({quotient, remainder, busy, done, err} !== 35'd0) begin
            errors++;
            $display("FAIL reset_release q=%0d r=%0d busy=%b done=%b err=%b expected all 0",
                     quotient, remainder, busy, done, err);
        end
    endtask

    task automatic test_directed;
        check_op("d100_7", 16'd100, 16'd7, 1'b1);
        check_op("d5_9", 16'd5, 16'd9, 1'b1);
        check_op("dffff_7", 16'hFFFF, 16'd7, 1'b0);
        check_op("d0_3", 16'd0, 16'd3, 1'b1);
        check_op("d42_42", 16'd42, 16'd42, 1'b1);
        check_op("dffff_ffff", 16'hFFFF, 16'hFFFF, 1'b1);
        check_op("d1_1", 16'd1, 16'd1, 1'b1);
    endtask

    task automatic test_div_zero;
        check_op("dz77", 16'd77, 16'd0, 1'b0);
    endtask

    task automatic test_random;
        logic [15:0] a, b;
        for (int i = 0; i < 25; i++) begin
            a = 16'($urandom);
            b = 16'($urandom_range(256, 65535));
            check_op("rand", a, b, 1'b1);
        end
    endtask

    task automatic test_handshake;
        start = 1'b1; data_in = 16'd10;
        @(posedge clk); #1;
        @(posedge clk); #1; data_in = 16'd3;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || quotient !== 16'd3 || remainder !== 16'd1) begin
                errors++;
                $display("FAIL hold_start_done cyc=%0d done=%b busy=%b q=%0d r=%0d expected 1 0 3 1",
                         i, done, busy, quotient, remainder);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || quotient !== 16'd3 || remainder !== 16'd1) begin
            errors++;
            $display("FAIL drop_start_idle done=%b busy=%b q=%0d r=%0d expected 0 0 3 1",
                     done, busy, quotient, remainder);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_restart busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_start_during_calc;
        int unsigned edges;
        start = 1'b1; data_in = 16'd200; edges = 0;
        @(posedge clk); #1; edges = 1; start = 1'b0;
        @(posedge clk); #1; edges = 2; data_in = 16'd2;
        while (!done && edges < 300) begin
            start = (edges == 20 || edges == 21);
            @(posedge clk); #1; edges++;
        end
        start = 1'b0;
        checks++;
        if (edges != 105 || quotient !== 16'd100 || remainder !== 16'd0 || done !== 1'b1) begin
            errors++;
            $display("FAIL start_in_calc edges=%0d q=%0d r=%0d done=%b expected 105 100 0 1",
                     edges, quotient, remainder, done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_calc;
        start = 1'b1; data_in = 16'd1000;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; data_in = 16'd1;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({quotient, remainder, busy, done, err} !== 35'd0) begin
            errors++;
            $display("FAIL reset_mid_calc q=%0d r=%0d busy=%b done=%b err=%b expected all 0",
                     quotient, remainder, busy, done, err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle busy=%b done=%b expected 0 0", busy, done);
        end
        check_op("after_reset", 16'd50, 16'd6, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; data_in = '0;
        test_reset;
        test_directed;
        test_div_zero;
        test_random;
        test_handshake;
        test_start_during_calc;
        test_reset_mid_calc;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
